// File: rtl/mem_stage_hs_if.sv
// Handshake and bus bundle for the MEM stage: EX/MEM input side, data-memory
// request/response port, and MEM/WB output side.
interface mem_stage_hs_if #(
    parameter int XLEN = 64,
    parameter int RD_W = 6
);
    logic                exmem_valid;
    logic                exmem_ready;
    logic                mem_active;
    logic                load;
    logic [2:0]          funct3;
    logic [XLEN-1:0]     exmem_aluresult;
    logic [XLEN-1:0]     exmem_rs2;
    logic [RD_W-1:0]     exmem_rd;

    logic                dmem_req_valid;
    logic                dmem_req_ready;
    logic [XLEN-1:0]     dmem_req_addr;
    logic                dmem_req_we;
    logic [XLEN-1:0]     dmem_req_wdata;
    logic [XLEN/8-1:0]   dmem_req_wstrb;
    logic                dmem_resp_valid;
    logic [XLEN-1:0]     dmem_resp_data;

    logic                memwb_valid;
    logic                memwb_ready;
    logic [XLEN-1:0]     memwb_aluresult;
    logic [XLEN-1:0]     memwb_loadeddata;
    logic [RD_W-1:0]     memwb_rd;
    logic                memwb_is_load;
    logic [1:0]          memwb_fault;

    // slave = the MEM stage itself
    modport slave (
        input  exmem_valid, mem_active, load, funct3, exmem_aluresult, exmem_rs2, exmem_rd,
               dmem_req_ready, dmem_resp_valid, dmem_resp_data, memwb_ready,
        output exmem_ready, dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata,
               dmem_req_wstrb, memwb_valid, memwb_aluresult, memwb_loadeddata, memwb_rd,
               memwb_is_load, memwb_fault
    );

    modport master (
        output exmem_valid, mem_active, load, funct3, exmem_aluresult, exmem_rs2, exmem_rd,
               dmem_req_ready, dmem_resp_valid, dmem_resp_data, memwb_ready,
        input  exmem_ready, dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata,
               dmem_req_wstrb, memwb_valid, memwb_aluresult, memwb_loadeddata, memwb_rd,
               memwb_is_load, memwb_fault
    );
endinterface

// File: rtl/mem_stage_hs.sv
// RISC-V MEM stage with valid/ready on both pipeline sides, a req/resp data
// memory port, load extension, store strobes, and misalign/timeout faults.
module mem_stage_hs #(
    parameter int XLEN         = 64,
    parameter int RD_W         = 6,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_hs_if.slave  bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;
    state_t state, state_n;

    logic              ld_r;
    logic [2:0]        f3_r;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   rs2_r;
    logic [RD_W-1:0]   rd_r;
    logic [31:0]       cnt;
    logic              stale;

    logic [XLEN-1:0]   wb_alu;
    logic [XLEN-1:0]   wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_isld;
    logic [1:0]        wb_fault;

    logic              accept, bad_in, illegal, misal, req_fire, timeout_hit;
    state_t            acc_next;
    logic [OFF_W-1:0]  off;
    logic [3:0]        nbytes;
    logic [6:0]        nbits;
    logic [NB-1:0]     strb_base;
    logic [XLEN-1:0]   lane, ld_ext;
    logic              msb;

    assign off     = addr_r[OFF_W-1:0];
    assign nbytes  = 4'd1 << f3_r[1:0];
    assign nbits   = 7'd8 << f3_r[1:0];

    assign bus.exmem_ready = (state == IDLE) || (state == OUT && bus.memwb_ready);
    assign accept          = bus.exmem_valid && bus.exmem_ready;
    assign bus.dmem_req_valid = (state == REQ) && !stale;
    assign req_fire        = bus.dmem_req_valid && bus.dmem_req_ready;
    assign timeout_hit     = (RESP_TIMEOUT > 0) && (cnt == 32'(RESP_TIMEOUT - 1));

    // Size legality and alignment of the incoming entry
    always_comb begin
        illegal = bus.load ? (bus.funct3 == 3'b111) : bus.funct3[2];
        if (XLEN == 32 && (bus.funct3 == 3'b011 || bus.funct3 == 3'b110))
            illegal = 1'b1;
        case (bus.funct3[1:0])
            2'b01:   misal = bus.exmem_aluresult[0];
            2'b10:   misal = |bus.exmem_aluresult[1:0];
            2'b11:   misal = |bus.exmem_aluresult[2:0];
            default: misal = 1'b0;
        endcase
        bad_in   = illegal || misal;
        acc_next = (!bus.mem_active || bad_in) ? OUT : REQ;
    end

    // Request fields read only from registered entry, so they stay stable in REQ
    always_comb begin
        strb_base = '0;
        for (int i = 0; i < NB; i++)
            strb_base[i] = (i < int'(nbytes));
    end

    assign bus.dmem_req_we    = (state == REQ) && !ld_r;
    assign bus.dmem_req_addr  = (state == REQ) ? {addr_r[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.dmem_req_wstrb = bus.dmem_req_we ? (strb_base << off) : '0;
    assign bus.dmem_req_wdata = bus.dmem_req_we ? (rs2_r << {off, 3'b000}) : '0;

    // Lane select then sign/zero extension from the access width
    always_comb begin
        lane = bus.dmem_resp_data >> {off, 3'b000};
        msb  = 1'b0;
        for (int i = 0; i < XLEN; i++)
            if (i == int'(nbits) - 1) msb = lane[i];
        ld_ext = '0;
        for (int i = 0; i < XLEN; i++)
            ld_ext[i] = (i < int'(nbits)) ? lane[i] : (msb & ~f3_r[2]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = acc_next;
            REQ:     if (req_fire) state_n = RESP;
            RESP:    if (bus.dmem_resp_valid || timeout_hit) state_n = OUT;
            OUT:     if (bus.memwb_ready) state_n = accept ? acc_next : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_r     <= 1'b0;
            f3_r     <= '0;
            addr_r   <= '0;
            rs2_r    <= '0;
            rd_r     <= '0;
            cnt      <= '0;
            stale    <= 1'b0;
            wb_alu   <= '0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_isld  <= 1'b0;
            wb_fault <= '0;
        end else begin
            if (accept) begin
                ld_r   <= bus.load;
                f3_r   <= bus.funct3;
                addr_r <= bus.exmem_aluresult;
                rs2_r  <= bus.exmem_rs2;
                rd_r   <= bus.exmem_rd;
                // Entries that never touch memory are final right now
                if (!bus.mem_active || bad_in) begin
                    wb_alu   <= bus.exmem_aluresult;
                    wb_data  <= '0;
                    wb_rd    <= bus.mem_active ? '0 : bus.exmem_rd;
                    wb_isld  <= 1'b0;
                    wb_fault <= bus.mem_active ? 2'b01 : 2'b00;
                end
            end

            if (state == REQ)       cnt <= '0;
            else if (state == RESP) cnt <= cnt + 32'd1;

            if (state == RESP) begin
                if (bus.dmem_resp_valid) begin
                    wb_alu   <= addr_r;
                    wb_data  <= ld_r ? ld_ext : '0;
                    wb_rd    <= ld_r ? rd_r : '0;
                    wb_isld  <= ld_r;
                    wb_fault <= 2'b00;
                end else if (timeout_hit) begin
                    wb_alu   <= addr_r;
                    wb_data  <= '0;
                    wb_rd    <= '0;
                    wb_isld  <= 1'b0;
                    wb_fault <= 2'b10;
                    stale    <= 1'b1;
                end
            end else if (stale && bus.dmem_resp_valid) begin
                // Late answer to the timed-out request: swallow it
                stale <= 1'b0;
            end
        end
    end

    assign bus.memwb_valid      = (state == OUT);
    assign bus.memwb_aluresult  = wb_alu;
    assign bus.memwb_loadeddata = wb_data;
    assign bus.memwb_rd         = wb_rd;
    assign bus.memwb_is_load    = wb_isld;
    assign bus.memwb_fault      = wb_fault;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed plus randomized checks of mem_stage_hs against a byte-level model
// of RISC-V load/store semantics (XLEN=64, RESP_TIMEOUT=4).
module tb_mem_stage_hs;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_hs_if #(.XLEN(64), .RD_W(6)) bus ();
    mem_stage_hs #(.XLEN(64), .RD_W(6), .RESP_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_bad(input bit ld, input logic [2:0] f3, input logic [63:0] a);
        bit legal;
        legal = ld ? (f3 != 3'b111) : !f3[2];
        return !legal || ((int'(a[2:0]) % nbytes(f3)) != 0);
    endfunction

    // Gather the accessed bytes, then extend from the top accessed bit
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] d);
        int n, off;
        logic [63:0] v;
        n = nbytes(f3);
        off = int'(a[2:0]);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
        if (!f3[2] && v[8*n-1])
            for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [2:0] f3, input logic [63:0] a);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < nbytes(f3); i++) s[int'(a[2:0]) + i] = 1'b1;
        return s;
    endfunction

    task automatic chk_req(input string tag, input bit ld, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] rs2);
        chk({tag, " req_valid"}, 64'(bus.dmem_req_valid), 64'd1);
        chk({tag, " req_addr"},  bus.dmem_req_addr, a & ~64'h7);
        chk({tag, " req_we"},    64'(bus.dmem_req_we), 64'(!ld));
        if (!ld) begin
            chk({tag, " wstrb"}, 64'(bus.dmem_req_wstrb), 64'(ref_strb(f3, a)));
            chk({tag, " wdata"}, bus.dmem_req_wdata, rs2 << (8 * int'(a[2:0])));
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] alu, input logic [63:0] data,
                           input logic [5:0] rd, input bit isld, input logic [1:0] fault);
        chk({tag, " wb_valid"},  64'(bus.memwb_valid), 64'd1);
        chk({tag, " wb_alu"},    bus.memwb_aluresult, alu);
        chk({tag, " wb_data"},   bus.memwb_loadeddata, data);
        chk({tag, " wb_rd"},     64'(bus.memwb_rd), 64'(rd));
        chk({tag, " wb_isload"}, 64'(bus.memwb_is_load), 64'(isld));
        chk({tag, " wb_fault"},  64'(bus.memwb_fault), 64'(fault));
    endtask

    // One complete entry from IDLE back to IDLE with optional stalls on each side
    task automatic do_op(input bit mem, input bit ld, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] rs2, input logic [5:0] rd,
                         input logic [63:0] rdata, input int req_wait, input int resp_wait,
                         input int wb_stall, input string tag);
        bit bad;
        logic [63:0] e_data;
        logic [5:0]  e_rd;
        bit          e_isld;
        logic [1:0]  e_fault;
        bad = mem && is_bad(ld, f3, a);
        e_data = '0; e_isld = 1'b0; e_fault = 2'b00; e_rd = 6'd0;
        if (!mem) e_rd = rd;
        else if (bad) e_fault = 2'b01;
        else if (ld) begin
            e_rd = rd; e_data = ref_load(f3, a, rdata); e_isld = 1'b1;
        end

        bus.exmem_valid = 1'b1; bus.mem_active = mem; bus.load = ld; bus.funct3 = f3;
        bus.exmem_aluresult = a; bus.exmem_rs2 = rs2; bus.exmem_rd = rd;
        bus.dmem_req_ready = 1'b0; bus.memwb_ready = (wb_stall == 0);
        tick();
        bus.exmem_valid = 1'b0;
        bus.exmem_aluresult = {$urandom, $urandom}; bus.exmem_rs2 = {$urandom, $urandom};
        bus.exmem_rd = 6'($urandom); bus.funct3 = 3'($urandom); bus.load = 1'($urandom);

        if (mem && !bad) begin
            for (int k = 0; k < req_wait; k++) begin
                chk_req({tag, " hold"}, ld, f3, a, rs2);
                tick();
            end
            chk_req(tag, ld, f3, a, rs2);
            bus.dmem_req_ready = 1'b1;
            tick();
            bus.dmem_req_ready = 1'b0;
            chk({tag, " req_dropped"}, 64'(bus.dmem_req_valid), 64'd0);
            for (int k = 0; k < resp_wait; k++) begin
                chk({tag, " wait_valid"}, 64'(bus.memwb_valid), 64'd0);
                tick();
            end
            bus.dmem_resp_valid = 1'b1; bus.dmem_resp_data = rdata;
            tick();
            bus.dmem_resp_valid = 1'b0; bus.dmem_resp_data = {$urandom, $urandom};
        end else begin
            chk({tag, " no_req"}, 64'(bus.dmem_req_valid), 64'd0);
        end

        chk_out(tag, a, e_data, e_rd, e_isld, e_fault);
        for (int k = 0; k < wb_stall; k++) begin
            tick();
            chk_out({tag, " stall"}, a, e_data, e_rd, e_isld, e_fault);
            chk({tag, " stall_ready"}, 64'(bus.exmem_ready), 64'd0);
        end
        bus.memwb_ready = 1'b1;
        tick();
        chk({tag, " drained"}, 64'(bus.memwb_valid), 64'd0);
    endtask

    // Load that never gets a response: fault 10 after exactly four RESP cycles
    task automatic timeout_op(input logic [63:0] a, input string tag);
        bus.exmem_valid = 1'b1; bus.mem_active = 1'b1; bus.load = 1'b1; bus.funct3 = 3'b011;
        bus.exmem_aluresult = a; bus.exmem_rd = 6'd9;
        bus.dmem_req_ready = 1'b1; bus.memwb_ready = 1'b1;
        tick();
        bus.exmem_valid = 1'b0;
        chk({tag, " req"}, 64'(bus.dmem_req_valid), 64'd1);
        tick();
        bus.dmem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, " resp_wait"}, 64'(bus.memwb_valid), 64'd0);
            tick();
        end
        chk_out(tag, a, 64'd0, 6'd0, 1'b0, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit mem, ld;
        logic [2:0]  f3;
        logic [63:0] a, v;

        reset = 1'b1;
        bus.exmem_valid = 1'b0; bus.mem_active = 1'b0; bus.load = 1'b0; bus.funct3 = '0;
        bus.exmem_aluresult = '0; bus.exmem_rs2 = '0; bus.exmem_rd = '0;
        bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0; bus.dmem_resp_data = '0;
        bus.memwb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst exmem_ready", 64'(bus.exmem_ready), 64'd1);
        chk("rst memwb_valid", 64'(bus.memwb_valid), 64'd0);
        chk("rst req_valid",   64'(bus.dmem_req_valid), 64'd0);
        chk("rst req_addr",    bus.dmem_req_addr, 64'd0);
        chk("rst wstrb",       64'(bus.dmem_req_wstrb), 64'd0);
        chk("rst wb_alu",      bus.memwb_aluresult, 64'd0);
        chk("rst wb_fault",    64'(bus.memwb_fault), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Directed cases
        do_op(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 6'd5, 64'd0, 0, 0, 0, "alu");
        do_op(1'b1, 1'b1, 3'b000, 64'h1003, 64'd0, 6'd7, 64'h0000_0000_8000_0000, 0, 0, 0, "lb");
        do_op(1'b1, 1'b1, 3'b100, 64'h1003, 64'd0, 6'd7, 64'h0000_0000_8000_0000, 0, 0, 0, "lbu");
        do_op(1'b1, 1'b1, 3'b010, 64'h1004, 64'd0, 6'd8, 64'h8765_4321_0000_0000, 0, 0, 0, "lw");
        do_op(1'b1, 1'b0, 3'b001, 64'h1006, 64'hBEEF, 6'd3, 64'd0, 3, 1, 0, "sh");
        do_op(1'b1, 1'b1, 3'b011, 64'h1008, 64'd0, 6'd4, 64'hF00D_CAFE_1234_5678, 0, 2, 4, "ld_wbstall");
        do_op(1'b1, 1'b1, 3'b010, 64'h1002, 64'd0, 6'd6, 64'd0, 0, 0, 0, "lw_misal");
        do_op(1'b1, 1'b1, 3'b111, 64'h1000, 64'd0, 6'd6, 64'd0, 0, 0, 0, "ld_f3_111");
        do_op(1'b1, 1'b0, 3'b110, 64'h1000, 64'h55, 6'd6, 64'd0, 0, 0, 2, "st_illegal");

        // Back-to-back non-memory entries, one per cycle
        bus.memwb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = 64'h100 + 64'(i) * 64'h111;
            bus.exmem_valid = 1'b1; bus.mem_active = 1'b0;
            bus.exmem_aluresult = v; bus.exmem_rd = 6'(i + 1);
            tick();
            chk("b2b valid", 64'(bus.memwb_valid), 64'd1);
            chk("b2b alu",   bus.memwb_aluresult, v);
            chk("b2b rd",    64'(bus.memwb_rd), 64'(i + 1));
            chk("b2b ready", 64'(bus.exmem_ready), 64'd1);
        end
        bus.exmem_valid = 1'b0;
        tick();
        chk("b2b end", 64'(bus.memwb_valid), 64'd0);

        // Randomized mix against the model
        for (int i = 0; i < 40; i++) begin
            mem = ($urandom_range(0, 3) != 0);
            ld  = 1'($urandom);
            f3  = 3'($urandom);
            a   = 64'h2000 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            do_op(mem, ld, f3, a, {$urandom, $urandom}, 6'($urandom), {$urandom, $urandom},
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), "rnd");
        end

        // Timeout, stale response swallowed, next load stalls until it arrives
        timeout_op(64'h3000, "tmo");
        tick();
        chk("tmo drained", 64'(bus.memwb_valid), 64'd0);
        bus.exmem_valid = 1'b1; bus.mem_active = 1'b1; bus.load = 1'b1; bus.funct3 = 3'b010;
        bus.exmem_aluresult = 64'h3004; bus.exmem_rd = 6'd10; bus.dmem_req_ready = 1'b1;
        tick();
        bus.exmem_valid = 1'b0;
        chk("stale blk0", 64'(bus.dmem_req_valid), 64'd0);
        tick();
        chk("stale blk1", 64'(bus.dmem_req_valid), 64'd0);
        bus.dmem_resp_valid = 1'b1; bus.dmem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.dmem_resp_valid = 1'b0;
        chk("stale clr req", 64'(bus.dmem_req_valid), 64'd1);
        tick();
        bus.dmem_req_ready = 1'b0;
        bus.dmem_resp_valid = 1'b1; bus.dmem_resp_data = 64'h1122_3344_5566_7788;
        tick();
        bus.dmem_resp_valid = 1'b0;
        chk_out("after stale", 64'h3004, ref_load(3'b010, 64'h3004, 64'h1122_3344_5566_7788),
                6'd10, 1'b1, 2'b00);
        tick();

        // Reset while waiting in RESP
        bus.exmem_valid = 1'b1; bus.mem_active = 1'b1; bus.load = 1'b1; bus.funct3 = 3'b011;
        bus.exmem_aluresult = 64'h4000; bus.dmem_req_ready = 1'b1;
        tick();
        bus.exmem_valid = 1'b0;
        tick();
        bus.dmem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_resp memwb_valid", 64'(bus.memwb_valid), 64'd0);
        chk("rst_resp exmem_ready", 64'(bus.exmem_ready), 64'd1);
        chk("rst_resp req_valid",   64'(bus.dmem_req_valid), 64'd0);
        chk("rst_resp wb_alu",      bus.memwb_aluresult, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Reset also clears stale: the next load must request immediately
        timeout_op(64'h5000, "tmo2");
        reset = 1'b1;
        #1;
        chk("rst_out memwb_valid", 64'(bus.memwb_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        do_op(1'b1, 1'b1, 3'b001, 64'h5002, 64'd0, 6'd12, 64'h0000_0000_8001_0000, 0, 0, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
